fetch_unit: RTL and testbench

//  Instruction-fetch stage that feeds the main control decoder. Holds the PC and

---
 rtl/fetch_unit.sv | 105 ++++++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: holds the PC, fetches over a req/ack handshake and
// computes the next PC from branch/zero results returned by execute.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  output logic [31:0] instruction,
  output logic [10:0] opcode,
  output logic [63:0] pc,
  input  logic        exec_done,
  input  logic        branch,
  input  logic        uncond_branch,
  input  logic        zero,
  input  logic [63:0] signext_imm,
  output logic        fetch_err
);

  localparam int unsigned CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, ERR} state_t;

  state_t         state_q, state_d;
  logic [63:0]    pc_q, pc_d;
  logic [31:0]    instr_q, instr_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [CW-1:0]  wait_q, wait_d;
  logic [63:0]    next_pc;
  logic           take;

  assign take    = uncond_branch | (branch & zero);
  assign next_pc = take ? pc_q + (signext_imm << 2) : pc_q + 64'd4;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    wait_d  = wait_q;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ack) begin
          instr_d = imem_data;
          valid_d = 1'b1;
          wait_d  = '0;
          state_d = EXEC;
        end else if (wait_q == WAIT_LAST) begin
          err_d   = 1'b1;
          state_d = ERR;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      EXEC: begin
        if (exec_done) begin
          pc_d    = next_pc;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      wait_q  <= wait_d;
    end
  end

  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign instruction = instr_q;
  assign opcode      = instr_q[31:21];
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: reset, fetch handshake,
// sequential/branch PC updates, timeout error and reset recovery.
module tb_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_data = '0;
  logic        instr_valid;
  logic [31:0] instruction;
  logic [10:0] opcode;
  logic [63:0] pc;
  logic        exec_done = 1'b0;
  logic        branch = 1'b0;
  logic        uncond_branch = 1'b0;
  logic        zero = 1'b0;
  logic [63:0] signext_imm = '0;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  fetch_unit #(.RESET_PC(64'h0), .MAX_WAIT(8)) dut (
    .CLK(CLK), .Reset(Reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(instr_valid),
    .instruction(instruction), .opcode(opcode), .pc(pc), .exec_done(exec_done),
    .branch(branch), .uncond_branch(uncond_branch), .zero(zero),
    .signext_imm(signext_imm), .fetch_err(fetch_err)
  );

  always #5 CLK = ~CLK;

  // One rising edge, then settle 1ns so outputs are sampled away from the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    Reset = 1'b0;
  endtask

  // From IDLE: one edge to FETCH.
  task automatic to_fetch();
    step();
  endtask

  // In FETCH: ack in the first cycle.
  task automatic ack_now(input logic [31:0] data);
    imem_ack = 1'b1; imem_data = data;
    step();
    imem_ack = 1'b0;
  endtask

  // In EXEC: retire with the given branch inputs.
  task automatic retire(input logic br, input logic ub, input logic z, input logic [63:0] imm);
    branch = br; uncond_branch = ub; zero = z; signext_imm = imm; exec_done = 1'b1;
    step();
    exec_done = 1'b0; branch = 1'b0; uncond_branch = 1'b0; zero = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    step(); step();
    checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b0 || fetch_err !== 1'b0 ||
        pc !== 64'h0 || instruction !== 32'h0) begin
      failures++;
      $display("FAIL reset_state: req=%b valid=%b err=%b pc=%h instr=%h, want 0 0 0 0 0",
               imem_req, instr_valid, fetch_err, pc, instruction);
    end
    Reset = 1'b0;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      failures++;
      $display("FAIL first_req: req=%b addr=%h, want 1 0", imem_req, imem_addr);
    end
  endtask

  task automatic test_fetch();
    step(); step();
    checks++;
    if (imem_req !== 1'b1 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL fetch_wait: req=%b valid=%b err=%b, want 1 0 0", imem_req, instr_valid, fetch_err);
    end
    ack_now(32'hF84003E9);
    checks++;
    if (instr_valid !== 1'b1 || opcode !== 11'b11111000010 || pc !== 64'h0 ||
        fetch_err !== 1'b0 || imem_req !== 1'b0 || instruction !== 32'hF84003E9) begin
      failures++;
      $display("FAIL fetch_ack: valid=%b opcode=%b pc=%h err=%b req=%b instr=%h, want 1 11111000010 0 0 0 f84003e9",
               instr_valid, opcode, pc, fetch_err, imem_req, instruction);
    end
  endtask

  task automatic test_sequential();
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'd4 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL seq_next: req=%b addr=%h valid=%b, want 1 4 0", imem_req, imem_addr, instr_valid);
    end
  endtask

  task automatic test_branch();
    // exec_done in FETCH is ignored
    exec_done = 1'b1; branch = 1'b1; zero = 1'b1; signext_imm = 64'd3;
    step();
    exec_done = 1'b0; branch = 1'b0; zero = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || pc !== 64'd4) begin
      failures++;
      $display("FAIL done_in_fetch: req=%b pc=%h, want 1 4", imem_req, pc);
    end
    ack_now(32'h12345678);
    // ack in EXEC is ignored
    imem_ack = 1'b1; imem_data = 32'hDEADBEEF;
    step();
    imem_ack = 1'b0;
    checks++;
    if (instruction !== 32'h12345678 || instr_valid !== 1'b1 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL ack_in_exec: instr=%h valid=%b req=%b, want 12345678 1 0", instruction, instr_valid, imem_req);
    end
    retire(1'b1, 1'b0, 1'b1, 64'd3);
    checks++;
    if (pc !== 64'd16 || imem_addr !== 64'd16) begin
      failures++;
      $display("FAIL cbz_taken: pc=%h addr=%h, want 10 10", pc, imem_addr);
    end
    do_reset(); to_fetch(); ack_now(32'h0); retire(1'b0, 1'b0, 1'b0, 64'd0);
    ack_now(32'h0);
    retire(1'b1, 1'b0, 1'b0, 64'd3);
    checks++;
    if (pc !== 64'd8) begin
      failures++;
      $display("FAIL cbz_not_taken: pc=%h, want 8", pc);
    end
  endtask

  task automatic test_uncond();
    ack_now(32'h0);
    retire(1'b1, 1'b0, 1'b1, 64'd2);
    checks++;
    if (pc !== 64'd16) begin
      failures++;
      $display("FAIL setup_16: pc=%h, want 10", pc);
    end
    ack_now(32'h0);
    retire(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (pc !== 64'd12) begin
      failures++;
      $display("FAIL b_back: pc=%h, want c", pc);
    end
    ack_now(32'h0);
    retire(1'b1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (pc !== 64'd8) begin
      failures++;
      $display("FAIL both_branch: pc=%h, want 8", pc);
    end
    do_reset(); to_fetch(); ack_now(32'h0);
    retire(1'b0, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
    checks++;
    if (pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin
      failures++;
      $display("FAIL b_wrap_low: pc=%h, want fffffffffffffffc", pc);
    end
    ack_now(32'h0);
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    checks++;
    if (pc !== 64'h0) begin
      failures++;
      $display("FAIL seq_wrap: pc=%h, want 0", pc);
    end
  endtask

  task automatic test_timeout();
    do_reset(); to_fetch();
    for (int i = 0; i < 7; i++) step();
    checks++;
    if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
      failures++;
      $display("FAIL req_cycle8: req=%b err=%b, want 1 0", imem_req, fetch_err);
    end
    step();
    checks++;
    if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err: req=%b err=%b valid=%b, want 0 1 0", imem_req, fetch_err, instr_valid);
    end
    imem_ack = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 4; i++) step();
    imem_ack = 1'b0; exec_done = 1'b0;
    checks++;
    if (imem_req !== 1'b0 || fetch_err !== 1'b1 || instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL err_sticky: req=%b err=%b valid=%b, want 0 1 0", imem_req, fetch_err, instr_valid);
    end
    do_reset();
    checks++;
    if (fetch_err !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL err_reset: err=%b req=%b, want 0 0", fetch_err, imem_req);
    end
    to_fetch();
    for (int i = 0; i < 7; i++) step();
    ack_now(32'hA5A5_0001);
    checks++;
    if (instr_valid !== 1'b1 || fetch_err !== 1'b0 || instruction !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL ack_cycle8: valid=%b err=%b instr=%h, want 1 0 a5a50001", instr_valid, fetch_err, instruction);
    end
  endtask

  task automatic test_reset_exec();
    retire(1'b0, 1'b0, 1'b0, 64'd0);
    ack_now(32'h0);
    retire(1'b1, 1'b0, 1'b1, 64'd4);
    ack_now(32'h0);
    checks++;
    if (pc !== 64'd20 || instr_valid !== 1'b1) begin
      failures++;
      $display("FAIL setup_20: pc=%h valid=%b, want 14 1", pc, instr_valid);
    end
    do_reset();
    checks++;
    if (pc !== 64'h0 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_in_exec: pc=%h valid=%b req=%b, want 0 0 0", pc, instr_valid, imem_req);
    end
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin
      failures++;
      $display("FAIL refetch: req=%b addr=%h, want 1 0", imem_req, imem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_sequential();
    test_branch();
    test_uncond();
    test_timeout();
    test_reset_exec();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
